// File: rtl/arith_op_controller.sv
// Sequencer for one FP add/sub: register-file read, EU STB/BUSY issue, write-back, done/next_pc report.
// Optional macro OPC_TIMEOUT_EN bounds the wait for an EU result to TIMEOUT_CYCLES cycles.
module arith_op_controller #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 5,
  parameter int PC_W            = 5,
  parameter int ZERO_RD_NOWRITE = 1,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [1:0]        i_op_type,
  input  logic              i_op_sub,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [ADDR_W-1:0] i_rs1_addr_in,
  input  logic [ADDR_W-1:0] i_rs2_addr_in,
  input  logic [ADDR_W-1:0] i_rd_addr_in,
  input  logic [DATA_W-1:0] i_imm,
  output logic [ADDR_W-1:0] o_rs1,
  output logic [ADDR_W-1:0] o_rs2,
  output logic [ADDR_W-1:0] o_rd,
  input  logic [DATA_W-1:0] i_rf_rdata1,
  input  logic [DATA_W-1:0] i_rf_rdata2,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_rf_we,
  output logic [DATA_W-1:0] o_eu_a,
  output logic [DATA_W-1:0] o_eu_b,
  output logic              o_eu_in_stb,
  input  logic              i_eu_in_busy,
  input  logic [DATA_W-1:0] i_eu_result,
  input  logic              i_eu_out_stb,
  output logic              o_eu_out_busy,
  output logic [PC_W-1:0]   o_next_pc,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_WB, S_FINISH
  } state_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [ADDR_W-1:0]   r_rd;
  logic                r_imm_sel;
  logic                r_sub;

`ifdef OPC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]    r_tmo_cnt;
`endif

  // Subtraction is realised by negating B: flip its sign bit.
  function automatic logic signed [DATA_W-1:0] f_operand_b(
    input logic signed [DATA_W-1:0] b,
    input logic                     sub
  );
    logic signed [DATA_W-1:0] v;
    v = b;
    v[DATA_W-1] = b[DATA_W-1] ^ sub;
    return v;
  endfunction

  logic signed [DATA_W-1:0] w_b_sel;
  assign w_b_sel = r_imm_sel ? i_imm : i_rf_rdata2;

  logic w_rd_write;
  assign w_rd_write = !((ZERO_RD_NOWRITE != 0) && (r_rd == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_rd          <= '0;
      r_imm_sel     <= 1'b0;
      r_sub         <= 1'b0;
      o_rs1         <= '0;
      o_rs2         <= '0;
      o_rd          <= '0;
      o_rf_wdata    <= '0;
      o_rf_we       <= 1'b0;
      o_eu_a        <= '0;
      o_eu_b        <= '0;
      o_eu_in_stb   <= 1'b0;
      o_eu_out_busy <= 1'b1;
      o_next_pc     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
`ifdef OPC_TIMEOUT_EN
      r_tmo_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (!i_op_type[1]) begin
              r_pc      <= i_pc;
              r_rd      <= i_rd_addr_in;
              r_imm_sel <= i_op_type[0];
              r_sub     <= i_op_sub;
              o_rs1     <= i_rs1_addr_in;
              o_rs2     <= i_rs2_addr_in;
              o_busy    <= 1'b1;
              o_done    <= 1'b0;
              o_err     <= 1'b0;
              r_state   <= S_LATCH;
            end else begin
              // Illegal opcode completes immediately without touching the EU or register file.
              o_done    <= 1'b1;
              o_err     <= 1'b1;
              o_next_pc <= i_pc + PC_W'(1);
            end
          end
        end
        S_LATCH: begin
          o_eu_a      <= i_rf_rdata1;
          o_eu_b      <= f_operand_b(w_b_sel, r_sub);
          o_eu_in_stb <= 1'b1;
          r_state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!i_eu_in_busy) begin
            o_eu_in_stb   <= 1'b0;
            o_eu_out_busy <= 1'b0;
`ifdef OPC_TIMEOUT_EN
            r_tmo_cnt     <= '0;
`endif
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_eu_out_stb && !o_eu_out_busy) begin
            o_eu_out_busy <= 1'b1;
            o_rf_wdata    <= i_eu_result;
            o_rd          <= r_rd;
            o_rf_we       <= w_rd_write;
            r_state       <= S_WB;
          end
`ifdef OPC_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            o_eu_out_busy <= 1'b1;
            o_err         <= 1'b1;
            r_state       <= S_FINISH;
          end else begin
            r_tmo_cnt     <= r_tmo_cnt + TMO_W'(1);
          end
`endif
        end
        S_WB: begin
          o_rf_we <= 1'b0;
          r_state <= S_FINISH;
        end
        S_FINISH: begin
          o_next_pc <= r_pc + PC_W'(1);
          o_busy    <= 1'b0;
          o_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
